// File: rtl/key_matrix_responder.sv
// Lets nine directly wired buttons answer a column-scanning keypad controller as a 3x3 matrix.
// Also publishes a debounced press mask and a queued one-cycle press-event stream.
module key_matrix_responder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] buttons,
    input  logic [2:0] column,
    output logic [2:0] row,
    output logic [8:0] pressed,
    output logic       key_valid,
    output logic [3:0] key
);

    localparam int unsigned NUM_KEYS = 9;
    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } db_state_t;

    logic [8:0]       level;
    logic [8:0]       sync_a;
    logic [8:0]       sync_b;
    db_state_t        state [NUM_KEYS];
    logic [CNT_W-1:0] cnt   [NUM_KEYS];
    logic [8:0]       accept_c;
    logic [8:0]       pending;
    logic [8:0]       low_mask_c;
    logic [3:0]       low_idx_c;
    logic [2:0]       row_c;

    // Internal level 1 = pressed regardless of button polarity.
    assign level = BTN_ACTIVE_LOW ? ~buttons : buttons;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= level;
            sync_b <= sync_a;
        end
    end

    // Per-key debounce FSMs; pressed[k] is their registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            pressed <= '0;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                state[k] <= IDLE;
                cnt[k]   <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                unique case (state[k])
                    IDLE: begin
                        if (sync_b[k]) begin
                            state[k] <= PRESS_PEND;
                            cnt[k]   <= CNT_W'(1);
                        end
                    end
                    PRESS_PEND: begin
                        if (!sync_b[k]) begin
                            state[k] <= IDLE;
                            cnt[k]   <= '0;
                        end else if (cnt[k] == CNT_MAX) begin
                            state[k]   <= PRESSED;
                            pressed[k] <= 1'b1;
                        end else begin
                            cnt[k] <= cnt[k] + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!sync_b[k]) begin
                            state[k] <= RELEASE_PEND;
                            cnt[k]   <= CNT_W'(1);
                        end
                    end
                    RELEASE_PEND: begin
                        if (sync_b[k]) begin
                            state[k] <= PRESSED;
                            cnt[k]   <= '0;
                        end else if (cnt[k] == CNT_MAX) begin
                            state[k]   <= IDLE;
                            pressed[k] <= 1'b0;
                        end else begin
                            cnt[k] <= cnt[k] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state[k] <= IDLE;
                        cnt[k]   <= '0;
                    end
                endcase
            end
        end
    end

    // Acceptance of a press this cycle mirrors the PRESS_PEND -> PRESSED transition.
    always_comb begin
        accept_c = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            accept_c[k] = (state[k] == PRESS_PEND) && sync_b[k] && (cnt[k] == CNT_MAX);
        end
    end

    // Lowest pending key is served first.
    always_comb begin
        low_idx_c  = '0;
        low_mask_c = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pending[k]) begin
                low_idx_c  = 4'(k);
                low_mask_c = 9'(1) << k;
            end
        end
    end

    // New acceptances are OR-ed in after the clear so a simultaneous set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            key_valid <= 1'b0;
            key       <= 4'd0;
        end else begin
            pending <= (pending & ~low_mask_c) | accept_c;
            if (pending != '0) begin
                key_valid <= 1'b1;
                key       <= low_idx_c;
            end else begin
                key_valid <= 1'b0;
            end
        end
    end

    // Only a single active-low strobe selects a column; anything else reads as no key.
    always_comb begin
        row_c = 3'b111;
        unique case (column)
            3'b110:  row_c = ~{pressed[6], pressed[3], pressed[0]};
            3'b101:  row_c = ~{pressed[7], pressed[4], pressed[1]};
            3'b011:  row_c = ~{pressed[8], pressed[5], pressed[2]};
            default: row_c = 3'b111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row <= 3'b111;
        end else begin
            row <= row_c;
        end
    end

endmodule

// File: tb/tb_key_matrix_responder.sv
// Bench for key_matrix_responder: directed scenarios plus randomized traffic against
// a run-length debounce model with a set-based event queue.
module tb_key_matrix_responder;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] buttons;
    logic [2:0] column;
    logic [2:0] row;
    logic [8:0] pressed;
    logic       key_valid;
    logic [3:0] key;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [8:0] m_q1, m_q2, m_pressed, m_pend;
    int         m_run [9];
    logic [2:0] m_row;
    logic       m_valid;
    logic [3:0] m_key;

    key_matrix_responder #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .buttons(buttons), .column(column),
        .row(row), .pressed(pressed), .key_valid(key_valid), .key(key)
    );

    always #5 clk = ~clk;

    // A key flips state after D+1 consecutive synchronized samples disagreeing with it.
    task automatic model_edge(input logic [8:0] lv, input logic [2:0] col, input logic rst);
        int nz, cz;
        bit found;
        if (rst) begin
            m_q1 = '0; m_q2 = '0; m_pressed = '0; m_pend = '0;
            m_row = 3'b111; m_valid = 1'b0; m_key = 4'd0;
            for (int k = 0; k < 9; k++) m_run[k] = 0;
        end else begin
            nz = 0; cz = 0;
            for (int c = 0; c < 3; c++) if (!col[c]) begin nz++; cz = c; end
            m_row = 3'b111;
            if (nz == 1) for (int r = 0; r < 3; r++) m_row[r] = ~m_pressed[3*r+cz];
            found = 1'b0;
            for (int k = 0; k < 9; k++) begin
                if (!found && m_pend[k]) begin
                    found = 1'b1; m_key = 4'(k); m_pend[k] = 1'b0;
                end
            end
            m_valid = found;
            for (int k = 0; k < 9; k++) begin
                if (m_q2[k] != m_pressed[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D + 1) begin
                        m_pressed[k] = m_q2[k];
                        m_run[k] = 0;
                        if (m_q2[k]) m_pend[k] = 1'b1;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_q2 = m_q1;
            m_q1 = lv;
        end
    endtask

    // lv is the pressed mask; buttons are active-low on the pins.
    task automatic step(input logic [8:0] lv, input logic [2:0] col, input logic rst);
        buttons = ~lv; column = col; reset = rst;
        @(posedge clk);
        model_edge(lv, col, rst);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(9'h1FF, 3'b110, 1'b1);
            vectors++;
            if (row !== 3'b111 || pressed !== 9'h000 || key_valid !== 1'b0 || key !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_state cyc%0d: row=%b pressed=%h kv=%b key=%0d required row=111 pressed=000 kv=0 key=0",
                         i, row, pressed, key_valid, key);
            end
        end
        for (int i = 0; i < 17; i++) begin
            step(9'h1FF, 3'b111, 1'b0);
            vectors++;
            if (pressed !== ((i >= 6) ? 9'h1FF : 9'h000)) begin
                miscompares++;
                $display("FAIL reset_rearm_pressed edge%0d: got %h required %h", i, pressed, (i >= 6) ? 9'h1FF : 9'h000);
            end
            vectors++;
            if (key_valid !== (i >= 7 && i <= 15) || (key_valid && key !== 4'(i - 7))) begin
                miscompares++;
                $display("FAIL reset_rearm_events edge%0d: kv=%b key=%0d required kv=%b key=%0d",
                         i, key_valid, key, (i >= 7 && i <= 15), i - 7);
            end
        end
        for (int i = 0; i < 8; i++) step(9'h000, 3'b111, 1'b0);
        vectors++;
        if (pressed !== 9'h000) begin
            miscompares++;
            $display("FAIL reset_release_all: got %h required 000", pressed);
        end
    endtask

    task automatic test_clean_press();
        for (int i = 0; i < 10; i++) begin
            step(9'h010, 3'b101, 1'b0);
            vectors++;
            if (pressed !== ((i >= 6) ? 9'h010 : 9'h000)) begin
                miscompares++;
                $display("FAIL clean_pressed edge%0d: got %h required %h", i, pressed, (i >= 6) ? 9'h010 : 9'h000);
            end
            vectors++;
            if (key_valid !== (i == 7) || (i == 7 && key !== 4'd4)) begin
                miscompares++;
                $display("FAIL clean_event edge%0d: kv=%b key=%0d required kv=%b key=4", i, key_valid, key, i == 7);
            end
            vectors++;
            if (row !== ((i >= 7) ? 3'b101 : 3'b111)) begin
                miscompares++;
                $display("FAIL clean_row edge%0d: got %b required %b", i, row, (i >= 7) ? 3'b101 : 3'b111);
            end
        end
        step(9'h010, 3'b110, 1'b0);
        vectors++;
        if (row !== 3'b111) begin
            miscompares++;
            $display("FAIL clean_row_other_col: got %b required 111", row);
        end
        for (int i = 0; i < 8; i++) step(9'h000, 3'b111, 1'b0);
    endtask

    task automatic test_bounce();
        logic [8:0] lv;
        for (int i = 0; i < 18; i++) begin
            lv = (i < 10 && ((i / 2) % 2) == 1) ? 9'h000 : 9'h004;
            step(lv, 3'b111, 1'b0);
            vectors++;
            if (pressed !== ((i >= 14) ? 9'h004 : 9'h000)) begin
                miscompares++;
                $display("FAIL bounce_pressed edge%0d: got %h required %h", i, pressed, (i >= 14) ? 9'h004 : 9'h000);
            end
            vectors++;
            if (key_valid !== (i == 15) || (i == 15 && key !== 4'd2)) begin
                miscompares++;
                $display("FAIL bounce_event edge%0d: kv=%b key=%0d required kv=%b key=2", i, key_valid, key, i == 15);
            end
        end
        for (int i = 0; i < 8; i++) step(9'h000, 3'b111, 1'b0);
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_key [3];
        exp_key[0] = 4'd0; exp_key[1] = 4'd5; exp_key[2] = 4'd8;
        for (int i = 0; i < 11; i++) begin
            step(9'h121, 3'b111, 1'b0);
            vectors++;
            if (pressed !== ((i >= 6) ? 9'h121 : 9'h000)) begin
                miscompares++;
                $display("FAIL simul_pressed edge%0d: got %h required %h", i, pressed, (i >= 6) ? 9'h121 : 9'h000);
            end
            vectors++;
            if (key_valid !== (i >= 7 && i <= 9) || (i >= 7 && i <= 9 && key !== exp_key[i - 7])) begin
                miscompares++;
                $display("FAIL simul_event edge%0d: kv=%b key=%0d required kv=%b", i, key_valid, key, (i >= 7 && i <= 9));
            end
        end
        for (int i = 0; i < 8; i++) step(9'h000, 3'b111, 1'b0);
    endtask

    task automatic test_column_scan();
        logic [2:0] cols [6];
        logic [2:0] rows [6];
        cols[0] = 3'b110; rows[0] = 3'b101;
        cols[1] = 3'b101; rows[1] = 3'b011;
        cols[2] = 3'b011; rows[2] = 3'b111;
        cols[3] = 3'b100; rows[3] = 3'b111;
        cols[4] = 3'b000; rows[4] = 3'b111;
        cols[5] = 3'b111; rows[5] = 3'b111;
        for (int i = 0; i < 9; i++) step(9'h088, 3'b111, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(9'h088, cols[i], 1'b0);
            vectors++;
            if (row !== rows[i]) begin
                miscompares++;
                $display("FAIL scan_row col=%b: got %b required %b", cols[i], row, rows[i]);
            end
        end
        for (int i = 0; i < 8; i++) step(9'h000, 3'b111, 1'b0);
    endtask

    task automatic test_release_reset();
        for (int i = 0; i < 9; i++) step(9'h002, 3'b111, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(9'h000, 3'b111, 1'b0);
            vectors++;
            if (pressed[1] !== (i < 6) || key_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL release edge%0d: pressed1=%b kv=%b required pressed1=%b kv=0", i, pressed[1], key_valid, i < 6);
            end
        end
        for (int i = 0; i < 4; i++) step(9'h040, 3'b111, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(9'h040, 3'b111, 1'b1);
            vectors++;
            if (pressed !== 9'h000 || key_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset cyc%0d: pressed=%h kv=%b required 000/0", i, pressed, key_valid);
            end
        end
        for (int i = 0; i < 9; i++) begin
            step(9'h040, 3'b111, 1'b0);
            vectors++;
            if (pressed[6] !== (i >= 6) || key_valid !== (i == 7) || (i == 7 && key !== 4'd6)) begin
                miscompares++;
                $display("FAIL post_reset edge%0d: pressed6=%b kv=%b key=%0d required pressed6=%b kv=%b key=6",
                         i, pressed[6], key_valid, key, i >= 6, i == 7);
            end
        end
        for (int i = 0; i < 8; i++) step(9'h000, 3'b111, 1'b0);
    endtask

    task automatic test_random();
        logic [8:0] lv;
        logic [2:0] ctab [8];
        logic       rst;
        ctab[0] = 3'b110; ctab[1] = 3'b101; ctab[2] = 3'b011; ctab[3] = 3'b110;
        ctab[4] = 3'b101; ctab[5] = 3'b011; ctab[6] = 3'b111; ctab[7] = 3'b000;
        lv = '0;
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 9; k++) if ($urandom_range(0, 5) == 0) lv[k] = ~lv[k];
            rst = ($urandom_range(0, 149) == 0);
            step(lv, ctab[$urandom_range(0, 7)], rst);
            vectors++;
            if (row !== m_row || pressed !== m_pressed || key_valid !== m_valid || key !== m_key) begin
                miscompares++;
                $display("FAIL random cyc%0d: row=%b pressed=%h kv=%b key=%0d required row=%b pressed=%h kv=%b key=%0d",
                         i, row, pressed, key_valid, key, m_row, m_pressed, m_valid, m_key);
            end
        end
    endtask

    initial begin
        buttons = 9'h1FF;
        column  = 3'b111;
        reset   = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_column_scan();
        test_release_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
